// File: rtl/cam_array.sv
// Content-addressable memory: DEPTH words of WIDTH bits with per-entry valid bits,
// addressed write/read/invalidate, global flush and a one-cycle registered search.
module cam_array #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable_i,
  input  logic [AW-1:0]    write_addr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             invalidate_i,
  input  logic             flush_i,
  input  logic             search_enable_i,
  input  logic [WIDTH-1:0] search_i,
  input  logic [AW-1:0]    read_addr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [DEPTH-1:0] match_o,
  output logic             hit_o,
  output logic             multi_hit_o,
  output logic [AW-1:0]    match_addr_o,
  output logic             match_valid_o
);

  localparam logic [AW:0]      DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [DEPTH-1:0] LSB_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] match_q, match_d;
  logic             hit_q, hit_d;
  logic             multi_hit_q, multi_hit_d;
  logic [AW-1:0]    match_addr_q, match_addr_d;
  logic             match_valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wr_in_range;
  logic             rd_in_range;

  // Only matters when DEPTH is not a power of two.
  assign wr_in_range = {1'b0, write_addr_i} < DEPTH_W;
  assign rd_in_range = {1'b0, read_addr_i}  < DEPTH_W;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_in_range) begin
      if (write_enable_i) valid_d[write_addr_i] = 1'b1;
      if (invalidate_i)   valid_d[write_addr_i] = 1'b0;
    end
  end

  // NOTE: storage has no reset; entries are unusable until written because valid_q clears on reset.
  always_ff @(posedge clk) begin
    if (write_enable_i && wr_in_range) begin
      mem_q[write_addr_i] <= data_i;
    end
  end

  always_comb begin
    match_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_d[k] = valid_q[k] && (mem_q[k] == search_i);
    end
  end

  always_comb begin
    match_addr_d = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_d[k]) match_addr_d = AW'(k);
    end
    hit_d       = |match_d;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    multi_hit_d = |(match_d & (match_d - LSB_ONE));
  end

  always_comb begin
    data_d = '0;
    if (rd_in_range) data_d = mem_q[read_addr_i];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      data_q        <= '0;
      match_q       <= '0;
      hit_q         <= 1'b0;
      multi_hit_q   <= 1'b0;
      match_addr_q  <= '0;
      match_valid_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      data_q        <= data_d;
      match_valid_q <= search_enable_i;
      if (search_enable_i) begin
        match_q      <= match_d;
        hit_q        <= hit_d;
        multi_hit_q  <= multi_hit_d;
        match_addr_q <= match_addr_d;
      end
    end
  end

  assign data_o        = data_q;
  assign match_o       = match_q;
  assign hit_o         = hit_q;
  assign multi_hit_o   = multi_hit_q;
  assign match_addr_o  = match_addr_q;
  assign match_valid_o = match_valid_q;

endmodule

// File: doc/cam_array.md
Name: cam_array

Overview:
- Parametrised content-addressable memory of DEPTH entries, each WIDTH bits, with a per-entry valid bit.
- Successor to the single-bit CAM flip-flop cell. Adds multi-bit words, addressed write/read/invalidate, a global flush, and a registered search pipeline with priority-encoded hit address and multi-hit detection.
- Sits behind the lookup-table controller. Driven from the testbench through a clocking-block interface.

Parameters:
- WIDTH, 8, bits per stored word and search key.
- DEPTH, 16, number of entries; must be >= 2.
- AW, $clog2(DEPTH), entry address width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- write_enable_i  input  1  write data_i into entry write_addr_i; sets its valid bit.
- write_addr_i  input  AW  target entry for write or invalidate.
- data_i  input  WIDTH  write data.
- invalidate_i  input  1  clear valid bit of entry write_addr_i.
- flush_i  input  1  clear all valid bits.
- search_enable_i  input  1  launch a search with key search_i.
- search_i  input  WIDTH  search key.
- read_addr_i  input  AW  read port address.
- data_o  output  WIDTH  registered read data of entry read_addr_i.
- match_o  output  DEPTH  registered per-entry match vector.
- hit_o  output  1  registered; at least one match_o bit set.
- multi_hit_o  output  1  registered; two or more match_o bits set.
- match_addr_o  output  AW  registered lowest index with match_o set; 0 when no hit.
- match_valid_o  output  1  registered; result of a search launched the previous cycle.

Behaviour:
- Reset (async assert, sync release):
  - All valid bits, data_o, match_o, hit_o, multi_hit_o, match_addr_o and match_valid_o go to 0.
  - Storage contents are don't-care but are never matched, because valid=0.
  - A search in flight when reset asserts is dropped: match_valid_o stays 0 the following cycle.
- Write: on posedge with write_enable_i=1, mem[write_addr_i] <= data_i and valid[write_addr_i] <= 1. Visible to search and read from the next cycle.
- Invalidate: on posedge with invalidate_i=1, valid[write_addr_i] <= 0. Data is kept.
- Flush: on posedge with flush_i=1, all valid bits <= 0.
- Precedence in one cycle:
  - flush_i beats everything.
  - invalidate_i beats write_enable_i at the same address; that entry ends invalid.
  - write_enable_i then sets valid only if flush_i=0 and invalidate_i=0.
- Search latency is 1 cycle:
  - On posedge with search_enable_i=1, match_o[k] <= valid[k] && (mem[k]==search_i) for every k.
  - Comparison uses pre-edge contents and valid bits. A write, invalidate or flush in the same cycle is not seen by that search.
  - match_valid_o <= search_enable_i every cycle.
  - When search_enable_i=0: match_o, hit_o, multi_hit_o and match_addr_o hold their last values; only match_valid_o drops.
- Back-to-back searches on every cycle are supported; throughput is one search per cycle.
- Priority: match_addr_o is the lowest matching index. hit_o = |match. multi_hit_o is set when popcount(match) >= 2. All derive from the same next-state match vector as match_o.
- Read: data_o <= mem[read_addr_i] every posedge, regardless of the valid bit. A same-cycle write to read_addr_i returns the old data (read-before-write).
- Out-of-range addresses (DEPTH not a power of 2):
  - Writes and invalidates with address >= DEPTH are ignored.
  - Reads with address >= DEPTH return 0.

Test Plan:
- Reset, then search 8'hAA with an empty array -> next cycle match_valid_o=1, hit_o=0, match_o=0, match_addr_o=0.
- Write 8'h3C to entry 5; next cycle search 8'h3C -> match_o=16'h0020, hit_o=1, multi_hit_o=0, match_addr_o=5.
- Write 8'h77 to entries 2, 9 and 14; search 8'h77 -> match_o=16'h4204, multi_hit_o=1, match_addr_o=2.
- Same-cycle hazards:
  - Write 8'h11 to entry 3 and search 8'h11 in the same cycle -> hit_o=0.
  - Repeat the search next cycle -> hit_o=1, match_addr_o=3.
  - Then invalidate 3 alongside a search -> hit_o=1.
  - Search again -> hit_o=0.
- Flush with writes and a valid search pending:
  - Fill entries 0..15 with k; assert flush_i together with write_enable_i to entry 7 of 8'h07 -> searching 8'h07 next cycle gives hit_o=0.
  - Read of entry 7 gives data_o=8'h07.
- Reset mid-search: assert reset between a search_enable_i edge and the result cycle -> match_valid_o=0 and all outputs 0 immediately (asynchronously).
